// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and default geometry for the direct-mapped instruction cache.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
  localparam int LINES = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
endpackage

// File: rtl/icache_fill_fsm.sv
// icache_fill_fsm: line-fill sequencer owning state, beat counter, base latch, abort flag and bus handshake.
module icache_fill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] base_in,
  output state_e            state,
  output logic [BEAT_W-1:0] beat,
  output logic [ADDR_W-1:0] base,
  output logic              abort,
  output logic              last_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr
);
  state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic abort_q, abort_d;
  always_comb begin
    mem_req  = state_q == FILL;
    mem_addr = mem_req ? base_q | ADDR_W'({beat_q, 2'b00}) : '0;
    last_ack = mem_req && mem_ack && beat_q == '1;
    state_d  = state_q == IDLE ? (start ? FILL : IDLE) :
               state_q == FILL ? (last_ack ? DONE : FILL) : IDLE;
    beat_d   = mem_req && mem_ack ? beat_q + BEAT_W'(1) : beat_q;
    base_d   = state_q == IDLE && start ? base_in : base_q;
    abort_d  = state_q == IDLE ? (start ? 1'b0 : abort_q) : abort_q | flush;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      abort_q <= abort_d;
    end
  end
  assign state = state_q;
  assign beat  = beat_q;
  assign base  = base_q;
  assign abort = abort_q;
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache; hit/miss counters built only with ICACHE_STATS_EN.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES          = icache_pkg::LINES,
  parameter int WORDS_PER_LINE = icache_pkg::WORDS_PER_LINE,
  parameter int ADDR_WIDTH     = icache_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PCF,
  input  logic                  FlushI,
  output logic [31:0]           InstrF,
  output logic                  IStallF,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_WIDTH - IW - OW - 2;
  logic [31:0] data_mem [LINES][WORDS_PER_LINE];
  logic [TW-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [OW-1:0] off, beat;
  logic [IW-1:0] idx, fill_idx;
  logic [ADDR_WIDTH-1:0] base, line_base;
  logic hit, start, abort, last_ack;
  state_e state;
  assign off       = PCF[2 +: OW];
  assign idx       = PCF[2+OW +: IW];
  assign fill_idx  = base[2+OW +: IW];
  assign line_base = {PCF[ADDR_WIDTH-1:OW+2], {(OW+2){1'b0}}};
  always_comb begin
    hit     = state == IDLE && valid_q[idx] && tag_mem[idx] == PCF[ADDR_WIDTH-1 -: TW];
    start   = state == IDLE && !hit;
    IStallF = !hit;
    InstrF  = hit ? data_mem[idx][off] : '0;
    valid_d = FlushI ? '0 : valid_q;
    if (last_ack && !abort && !FlushI) valid_d[fill_idx] = 1'b1;
  end
  icache_fill_fsm #(.ADDR_W(ADDR_WIDTH), .BEAT_W(OW)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flush    (FlushI),
    .mem_ack  (mem_ack),
    .base_in  (line_base),
    .state    (state),
    .beat     (beat),
    .base     (base),
    .abort    (abort),
    .last_ack (last_ack),
    .mem_req  (mem_req),
    .mem_addr (mem_addr)
  );
  always_ff @(posedge clk) begin
    valid_q <= reset ? '0 : valid_d;
    if (mem_req && mem_ack) data_mem[fill_idx][beat] <= mem_rdata;
    if (last_ack) tag_mem[fill_idx] <= base[ADDR_WIDTH-1 -: TW];
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(hit && hit_cnt_q != '1);
    miss_cnt_d = miss_cnt_q + 32'(start && miss_cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    hit_cnt_q  <= reset ? '0 : hit_cnt_d;
    miss_cnt_q <= reset ? '0 : miss_cnt_d;
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed test of icache_dm against a word bus returning 0xE000_0000+addr.
module tb_icache_dm;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, FlushI = 1'b0, mem_req, mem_ack, IStallF;
  logic [31:0] PCF = '0, InstrF, mem_addr, mem_rdata, hit_cnt, miss_cnt;
  int checks = 0, errors = 0, ack_wait = 0, wcnt = 0, n;
  logic [31:0] q[$];
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  icache_dm dut (
    .clk(clk), .reset(reset), .PCF(PCF), .FlushI(FlushI), .InstrF(InstrF), .IStallF(IStallF),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;
  assign mem_ack   = mem_req && wcnt == ack_wait;
  assign mem_rdata = 32'hE000_0000 + mem_addr;
  always @(posedge clk) wcnt <= (reset || !mem_req || mem_ack) ? 0 : wcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && prev_req && !prev_ack) begin
      chk("req_hold", {31'd0, mem_req}, 32'd1);
      chk("addr_hold", mem_addr, prev_addr);
    end
    if (mem_req && mem_ack) q.push_back(mem_addr);
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_addr = mem_addr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic samp;
    #4;
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (IStallF && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic chk_line(input logic [31:0] base);
    chk("beat_count", q.size(), 32'd4);
    for (int i = 0; i < 4 && i < q.size(); i++) chk("beat_addr", q[i], base + 32'(4 * i));
  endtask
  task automatic hit_word(input logic [31:0] pc);
    tick;
    PCF = pc;
    samp;
    chk("hit_stall", {31'd0, IStallF}, 32'd0);
    chk("hit_instr", InstrF, 32'hE000_0000 + pc);
    chk("hit_noreq", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    tick;
    tick;
    samp;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_stall", {31'd0, IStallF}, 32'd1);
    chk("rst_instr", InstrF, 32'd0);
    chk("rst_hits", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    // cold miss with zero-wait bus
    tick;
    reset = 1'b0;
    q.delete();
    samp;
    wait_ready(n);
    chk("t1_stall_cycles", n, 32'd6);
    chk("t1_instr", InstrF, 32'hE000_0000);
    chk_line(32'h0);
    hit_word(32'h4);
    hit_word(32'h8);
    hit_word(32'hC);
    // conflicting tag on index 0, then back again
    tick;
    q.delete();
    PCF = 32'h100;
    samp;
    wait_ready(n);
    chk("t3a_stall_cycles", n, 32'd6);
    chk("t3a_instr", InstrF, 32'hE000_0100);
    chk_line(32'h100);
    tick;
    q.delete();
    PCF = 32'h0;
    samp;
    wait_ready(n);
    chk("t3b_stall_cycles", n, 32'd6);
    chk("t3b_instr", InstrF, 32'hE000_0000);
    chk_line(32'h0);
    chk("t3_miss_cnt", miss_cnt, STATS ? 32'd3 : 32'd0);
    chk("t3_hit_cnt", hit_cnt, STATS ? 32'd5 : 32'd0);
    // slow bus with PCF wandering during the fill
    tick;
    q.delete();
    ack_wait = 3;
    PCF = 32'h200;
    tick;
    PCF = 32'h344;
    tick;
    PCF = 32'h200;
    tick;
    PCF = 32'h3F0;
    tick;
    PCF = 32'h200;
    samp;
    wait_ready(n);
    chk("t4_stall_cycles", n, 32'd14);
    chk("t4_instr", InstrF, 32'hE000_0200);
    chk_line(32'h200);
    // flush on beat 2 aborts the line but the fill still completes
    tick;
    q.delete();
    ack_wait = 0;
    PCF = 32'h400;
    tick;
    tick;
    tick;
    FlushI = 1'b1;
    tick;
    FlushI = 1'b0;
    tick;
    samp;
    chk("t5_done_stall", {31'd0, IStallF}, 32'd1);
    chk("t5_done_noreq", {31'd0, mem_req}, 32'd0);
    tick;
    samp;
    chk("t5_first_beats", q.size(), 32'd4);
    chk("t5_remiss_stall", {31'd0, IStallF}, 32'd1);
    wait_ready(n);
    chk("t5_refill_cycles", n, 32'd6);
    chk("t5_instr", InstrF, 32'hE000_0400);
    chk("t5_total_beats", q.size(), 32'd8);
    // flush while idle: this cycle still hits, next one misses
    tick;
    FlushI = 1'b1;
    samp;
    chk("t5_idle_flush_hit", {31'd0, IStallF}, 32'd0);
    tick;
    FlushI = 1'b0;
    samp;
    chk("t5_idle_flush_miss", {31'd0, IStallF}, 32'd1);
    wait_ready(n);
    chk("t5_idle_flush_cycles", n, 32'd6);
    // reset in the middle of a fill
    tick;
    ack_wait = 2;
    PCF = 32'h500;
    tick;
    tick;
    samp;
    chk("t6_in_fill", {31'd0, mem_req}, 32'd1);
    tick;
    reset = 1'b1;
    PCF = 32'h0;
    tick;
    samp;
    chk("t6_req", {31'd0, mem_req}, 32'd0);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_lookup_miss", {31'd0, IStallF}, 32'd1);
    chk("t6_hits", hit_cnt, 32'd0);
    chk("t6_miss", miss_cnt, 32'd0);
    tick;
    reset = 1'b0;
    ack_wait = 0;
    q.delete();
    samp;
    wait_ready(n);
    chk("t6_refill_cycles", n, 32'd6);
    chk("t6_instr", InstrF, 32'hE000_0000);
    chk_line(32'h0);
    chk("t6_miss_after", miss_cnt, STATS ? 32'd1 : 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
